// File: rtl/kernel_line_buffer.sv
// Line-buffered column generator: stores recent lines of an RGB565 stream and emits one
// KERNEL_SIZE-tall column of vertically adjacent pixels per accepted input pixel, 2 cycles later.

module klb_line_mem #(
    parameter int DEPTH = 320,
    parameter int AW    = 9
) (
    input  logic          clk_in,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [15:0]   i_wdata,
    output logic [15:0]   o_rdata
);
    logic [15:0] r_mem [DEPTH];
    logic [15:0] r_rdata;

    always_ff @(posedge clk_in) begin
        if (i_we) r_mem[i_addr] <= i_wdata;
        r_rdata <= r_mem[i_addr];
    end

    assign o_rdata = r_rdata;
endmodule

module kernel_line_buffer #(
    parameter int HRES        = 320,
    parameter int VRES        = 240,
    parameter int KERNEL_SIZE = 3
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [15:0]                  data_in,
    input  logic [10:0]                  hcount_in,
    input  logic [9:0]                   vcount_in,
    input  logic                         data_valid_in,
    output logic [KERNEL_SIZE-1:0][15:0] line_buffer_out,
    output logic [10:0]                  hcount_out,
    output logic [9:0]                   vcount_out,
    output logic                         data_valid_out
);
    localparam int NMEM = KERNEL_SIZE + 1;
    localparam int SW   = $clog2(NMEM);
    localparam int AW   = (HRES > 1) ? $clog2(HRES) : 1;
    localparam logic [10:0]        H_LIM  = 11'(HRES);
    localparam logic [10:0]        H_LAST = 11'(HRES - 1);
    localparam logic [SW-1:0]      SEL_MAX = SW'(KERNEL_SIZE);
    localparam logic signed [10:0] VRES_S = 11'(VRES);

    logic [SW-1:0]                  r_wr_sel, r_sel1;
    logic [2:1]                     r_vld_pipe;
    logic [10:0]                    r_h1, r_h2;
    logic [9:0]                     r_v1, r_v2;
    logic [KERNEL_SIZE-1:0][15:0]   r_col;
    logic [NMEM-1:0][15:0]          w_rd;
    logic                           w_accept;
    logic signed [10:0]             w_vdiff;
    logic [9:0]                     w_vout;

    assign w_accept = rst_in && data_valid_in && (hcount_in < H_LIM);

    always_comb begin
        w_vdiff = $signed({1'b0, vcount_in}) - 11'sd2;
        w_vout  = (w_vdiff < 0) ? 10'(w_vdiff + VRES_S) : 10'(w_vdiff);
    end

    // Row v-(K-k) lives in mem[(sel-(K-k)) mod (K+1)] == mem[(sel+k+1) mod (K+1)]
    function automatic logic [SW-1:0] row_sel(input logic [SW-1:0] sel, input int k);
        int s;
        s = int'(sel) + k + 1;
        if (s >= NMEM) s = s - NMEM;
        return SW'(s);
    endfunction

    for (genvar g = 0; g < NMEM; g++) begin : g_mem
        klb_line_mem #(.DEPTH(HRES), .AW(AW)) u_mem (
            .clk_in  (clk_in),
            .i_we    (w_accept && (r_wr_sel == SW'(g))),
            .i_addr  (hcount_in[AW-1:0]),
            .i_wdata (data_in),
            .o_rdata (w_rd[g])
        );
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            r_wr_sel   <= '0;
            r_sel1     <= '0;
            r_vld_pipe <= '0;
            r_h1       <= '0;
            r_v1       <= '0;
            r_h2       <= '0;
            r_v2       <= '0;
            r_col      <= '0;
        end else begin
            if (w_accept && hcount_in == H_LAST)
                r_wr_sel <= (r_wr_sel == SEL_MAX) ? '0 : r_wr_sel + SW'(1);
            // Select travels with the read so a line advance cannot re-route in-flight data
            r_sel1     <= r_wr_sel;
            r_vld_pipe <= {r_vld_pipe[1], w_accept};
            r_h1       <= hcount_in;
            r_v1       <= w_vout;
            r_h2       <= r_h1;
            r_v2       <= r_v1;
            for (int k = 0; k < KERNEL_SIZE; k++)
                r_col[k] <= w_rd[row_sel(r_sel1, k)];
        end
    end

    assign line_buffer_out = r_col;
    assign hcount_out      = r_h2;
    assign vcount_out      = r_v2;
    assign data_valid_out  = r_vld_pipe[2];
endmodule

// File: tb/tb_kernel_line_buffer.sv
// Randomized bench for kernel_line_buffer against a line-history reference model.

module tb_kernel_line_buffer;
    localparam int HRES = 4;
    localparam int VRES = 4;
    localparam int K    = 3;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic [15:0]       data_in;
    logic [10:0]       hcount_in;
    logic [9:0]        vcount_in;
    logic              data_valid_in;
    logic [K-1:0][15:0] line_buffer_out;
    logic [10:0]       hcount_out;
    logic [9:0]        vcount_out;
    logic              data_valid_out;

    kernel_line_buffer #(.HRES(HRES), .VRES(VRES), .KERNEL_SIZE(K)) dut (
        .clk_in          (clk_in),
        .rst_in          (rst_in),
        .data_in         (data_in),
        .hcount_in       (hcount_in),
        .vcount_in       (vcount_in),
        .data_valid_in   (data_valid_in),
        .line_buffer_out (line_buffer_out),
        .hcount_out      (hcount_out),
        .vcount_out      (vcount_out),
        .data_valid_out  (data_valid_out)
    );

    always #5 clk_in = ~clk_in;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic        valid;
        logic        zero;
        logic        dchk;
        logic [10:0] h;
        logic [9:0]  v;
        logic [47:0] d;
    } exp_t;

    // Model: hist[n][h] = last pixel written at column h of the n-th line since reset
    logic [15:0] hist [0:255][0:HRES-1];
    int          n_line = 0;
    exp_t        e_prev = '0;

    task automatic check_out(input exp_t e);
        chk("valid", 64'(data_valid_out), 64'(e.valid));
        if (e.zero) begin
            chk("rst_h",    64'(hcount_out),      64'(0));
            chk("rst_v",    64'(vcount_out),      64'(0));
            chk("rst_data", 64'(line_buffer_out), 64'(0));
        end
        if (e.valid) begin
            chk("hcount", 64'(hcount_out), 64'(e.h));
            chk("vcount", 64'(vcount_out), 64'(e.v));
            if (e.dchk) chk("column", 64'(line_buffer_out), 64'(e.d));
        end
    endtask

    task automatic step(input bit rst, input bit vld, input int h, input int v, input logic [15:0] d);
        exp_t e;
        e = '0;
        rst_in        = rst;
        data_valid_in = vld;
        hcount_in     = 11'(h);
        vcount_in     = 10'(v);
        data_in       = d;
        if (!rst) begin
            n_line = 0;
        end else if (vld && h < HRES) begin
            e.valid = 1'b1;
            e.h     = 11'(h);
            e.v     = 10'((v + VRES - 2) % VRES);
            if (n_line >= K) begin
                e.dchk = 1'b1;
                for (int k = 0; k < K; k++) e.d[k*16 +: 16] = hist[n_line-K+k][h];
            end
            hist[n_line][h] = d;
            if (h == HRES - 1) n_line++;
        end
        @(posedge clk_in); #1;
        if (!rst) begin
            e_prev      = '0;
            e_prev.zero = 1'b1;
        end
        check_out(e_prev);
        e_prev = e;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 16'($urandom));
    endtask

    task automatic rand_frames(input int nf);
        for (int f = 0; f < nf; f++)
            for (int v = 0; v < VRES; v++)
                for (int h = 0; h < HRES; h++) begin
                    while ($urandom_range(0, 2) == 0) idle();
                    if ($urandom_range(0, 5) == 0) step(1'b1, 1'b1, 5, v, 16'($urandom));
                    step(1'b1, 1'b1, h, v, 16'($urandom));
                end
    endtask

    initial begin
        step(1'b0, 1'b1, 1, 0, 16'h1234);
        step(1'b0, 1'b0, 0, 0, 16'h0);
        step(1'b1, 1'b0, 0, 0, 16'h0);

        // Back-to-back rows of pattern (v<<8)|h
        for (int v = 0; v < VRES; v++)
            for (int h = 0; h < HRES; h++) begin
                step(1'b1, 1'b1, h, v, 16'((v << 8) | h));
                if (v == 3 && h == 3) begin
                    chk("s1_col", 64'(line_buffer_out), 64'(48'h0202_0102_0002));
                    chk("s1_h",   64'(hcount_out), 64'(2));
                    chk("s1_v",   64'(vcount_out), 64'(1));
                end
            end
        step(1'b1, 1'b1, 0, 0, 16'h0000);
        step(1'b1, 1'b1, 1, 0, 16'h0001);
        chk("s2_col", 64'(line_buffer_out), 64'(48'h0300_0200_0100));
        chk("s2_v",   64'(vcount_out), 64'(2));
        step(1'b1, 1'b1, 2, 0, 16'h0002);
        step(1'b1, 1'b1, 3, 0, 16'h0003);

        // Alternating valid gaps on a repeat of the pattern
        for (int v = 1; v < VRES; v++)
            for (int h = 0; h < HRES; h++) begin
                step(1'b1, 1'b1, h, v, 16'((v << 8) | h));
                idle();
            end

        // Out-of-range hcount with valid high
        step(1'b1, 1'b1, 5, 0, 16'hdead);
        step(1'b1, 1'b0, 0, 0, 16'h0);
        chk("oob_vld", 64'(data_valid_out), 64'(0));

        rand_frames(4);

        // Reset mid-line with valid input, then fresh lines
        step(1'b1, 1'b1, 0, 1, 16'($urandom));
        step(1'b1, 1'b1, 1, 1, 16'($urandom));
        step(1'b0, 1'b1, 2, 1, 16'($urandom));
        rand_frames(4);

        idle();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
